// File: rtl/vga_game_pkg.sv
// Shared colours, game-state encoding and BCD helper for the VGA game compositor.
package vga_game_pkg;

  localparam logic [11:0] BLACK      = 12'h000;
  localparam logic [11:0] BACKGROUND = 12'h4CF;
  localparam logic [11:0] PIPE_COLOR = 12'h0A0;

  localparam int unsigned ROM_LAT = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDead = 2'd2
  } game_state_e;

  // Four-digit BCD increment that sticks at 9999.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] val);
    logic [15:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    if (val != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (res[4*i +: 4] == 4'd9) begin
            res[4*i +: 4] = 4'd0;
          end else begin
            res[4*i +: 4] = res[4*i +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_game_compositor_if.sv
// Pixel-stream bundle between the VGA timing/renderers and the compositor.
interface vga_game_compositor_if #(
  parameter int unsigned N_LAYERS = 2
);
  logic                    bright;
  logic [9:0]              hCount;
  logic [9:0]              vCount;
  logic [3:0]              sprite_row;
  logic [3:0]              sprite_col;
  logic [11:0]             sprite_px;
  logic [N_LAYERS-1:0]     layer_px;
  logic [12*N_LAYERS-1:0]  layer_rgb;
  logic [11:0]             rgb;

  modport master (
    output bright, hCount, vCount, sprite_px, layer_px, layer_rgb,
    input  sprite_row, sprite_col, rgb
  );

  modport slave (
    input  bright, hCount, vCount, sprite_px, layer_px, layer_rgb,
    output sprite_row, sprite_col, rgb
  );
endinterface

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score register with synchronous clear and saturating increment.
module bcd_score_counter
  import vga_game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] score
);

  logic [15:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (inc) begin
      score_d = bcd_inc_sat(score_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/vga_game_compositor.sv
// Playfield colouriser: sprite/layer compositing, game FSM, collision and score.
// Optional hit flash is enabled by defining VGA_COMP_HIT_FLASH_EN.
module vga_game_compositor
  import vga_game_pkg::*;
#(
  parameter int unsigned N_LAYERS     = 2,
  parameter int unsigned SPRITE_W     = 16,
  parameter int unsigned SPRITE_H     = 16,
  parameter int unsigned BIRD_X       = 200,
  parameter int unsigned FLOOR_Y      = 500,
  parameter logic [11:0] TRANSP       = 12'h0FF
`ifdef VGA_COMP_HIT_FLASH_EN
  ,
  parameter int unsigned FLASH_FRAMES = 8
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_game_compositor_if.slave  pix,
  input  logic                  start_button,
  input  logic [9:0]            bird_y,
  input  logic                  pass_pulse,
  output logic [15:0]           score,
  output logic                  pipe_run_en,
  output logic [1:0]            game_state
);

  localparam logic [10:0] XLo      = 11'(BIRD_X);
  localparam logic [10:0] XHi      = 11'(BIRD_X + SPRITE_W);
  localparam logic [10:0] SprH     = 11'(SPRITE_H);
  localparam logic [9:0]  FloorLim = 10'(FLOOR_Y - SPRITE_H);

  game_state_e state_q, state_d;

  // S0: sprite window test and ROM address
  logic [10:0] h_ext, v_ext, by_ext;
  logic        in_sprite;

  assign h_ext     = {1'b0, pix.hCount};
  assign v_ext     = {1'b0, pix.vCount};
  assign by_ext    = {1'b0, bird_y};
  assign in_sprite = (h_ext >= XLo) && (h_ext < XHi) &&
                     (v_ext >= by_ext) && (v_ext < by_ext + SprH);

  assign pix.sprite_row = pix.vCount[3:0] - bird_y[3:0];
  assign pix.sprite_col = pix.hCount[3:0] - 4'(BIRD_X);

  // S1: align everything with the ROM data
  logic                   bright_q, in_sprite_q;
  logic [N_LAYERS-1:0]    layer_px_q;
  logic [12*N_LAYERS-1:0] layer_rgb_q;
  logic [11:0]            rgb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q    <= 1'b0;
      in_sprite_q <= 1'b0;
      layer_px_q  <= '0;
      layer_rgb_q <= '0;
    end else begin
      bright_q    <= pix.bright;
      in_sprite_q <= in_sprite;
      layer_px_q  <= pix.layer_px;
      layer_rgb_q <= pix.layer_rgb;
    end
  end

  logic        opaque;
  logic [11:0] colour, shown;

  assign opaque = in_sprite_q && (pix.sprite_px != TRANSP);

  // Walk from the highest index down so the lowest set layer wins.
  always_comb begin
    colour = BACKGROUND;
    for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
      if (layer_px_q[i]) colour = layer_rgb_q[12*i +: 12];
    end
    if (opaque) colour = pix.sprite_px;
  end

  logic collision, score_clr, score_inc;

  assign collision = (state_q == StRun) &&
                     ((opaque && |layer_px_q) || (bird_y >= FloorLim));
  assign score_inc = (state_q == StRun) && pass_pulse && !collision;

  always_comb begin
    state_d   = state_q;
    score_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_button) begin
          state_d   = StRun;
          score_clr = 1'b1;
        end
      end
      StRun:   if (collision) state_d = StDead;
      StDead:  if (start_button) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef VGA_COMP_HIT_FLASH_EN
  localparam int unsigned FlashW = $clog2(FLASH_FRAMES + 1);

  logic [FlashW-1:0] flash_q, flash_d;
  logic              frame_start;

  assign frame_start = (pix.hCount == 10'd0) && (pix.vCount == 10'd0);

  always_comb begin
    flash_d = flash_q;
    if (state_q == StRun && state_d == StDead) begin
      flash_d = FlashW'(FLASH_FRAMES);
    end else if (state_q == StDead && state_d == StIdle) begin
      flash_d = '0;
    end else if (frame_start && flash_q != '0) begin
      flash_d = flash_q - FlashW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_q <= '0;
    end else begin
      flash_q <= flash_d;
    end
  end

  assign shown = (flash_q != '0) ? ~colour : colour;
`else
  assign shown = colour;
`endif

  // S2: registered output, blanked outside the visible region
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= BLACK;
    end else begin
      rgb_q <= bright_q ? shown : BLACK;
    end
  end

  assign pix.rgb = rgb_q;

  bcd_score_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .score (score)
  );

  assign pipe_run_en = (state_q == StRun);
  assign game_state  = state_q;

endmodule

// File: tb/tb_vga_game_compositor.sv
// Randomised bench for vga_game_compositor against a cycle-level behavioural model.
module tb_vga_game_compositor;
  import vga_game_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start_button, pass_pulse;
  logic [9:0]  bird_y;
  logic [15:0] score;
  logic        pipe_run_en;
  logic [1:0]  game_state;

  always #5 clk = ~clk;

  vga_game_compositor_if #(.N_LAYERS(2)) pix ();

  vga_game_compositor dut (
    .clk          (clk),
    .reset        (reset),
    .pix          (pix),
    .start_button (start_button),
    .bird_y       (bird_y),
    .pass_pulse   (pass_pulse),
    .score        (score),
    .pipe_run_en  (pipe_run_en),
    .game_state   (game_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] rom [16][16];

  // Model: game state as 0/1/2, score as a decimal integer, previous pixel record.
  int          m_state, m_score, m_flash;
  logic        m_br, m_in;
  int          m_row, m_col;
  logic [1:0]  m_lp;
  logic [23:0] m_lr;
  logic [11:0] m_rgb;
  logic [7:0]  addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  task automatic step(input logic rst, input logic st, input logic pp, input logic br,
                      input logic [9:0] h, input logic [9:0] v, input logic [9:0] by,
                      input logic [1:0] lp, input logic [23:0] lr);
    logic        ins, opaque, coll;
    logic [11:0] px, colour;
    int          nstate;
    reset        = rst;
    start_button = st;
    pass_pulse   = pp;
    bird_y       = by;
    pix.bright   = br;
    pix.hCount   = h;
    pix.vCount   = v;
    pix.layer_px = lp;
    pix.layer_rgb = lr;
    #1;
    ins = (int'(h) >= 200) && (int'(h) < 216) && (int'(v) >= int'(by)) && (int'(v) < int'(by) + 16);
    if (ins) begin
      check_eq("sprite_row", 32'(pix.sprite_row), 32'((int'(v) - int'(by)) & 15));
      check_eq("sprite_col", 32'(pix.sprite_col), 32'((int'(h) - 200) & 15));
    end
    addr = {pix.sprite_row, pix.sprite_col};

    px     = rom[m_row][m_col];
    opaque = m_in && (px != 12'h0FF);
    colour = BACKGROUND;
    if (m_lp[1]) colour = m_lr[23:12];
    if (m_lp[0]) colour = m_lr[11:0];
    if (opaque)  colour = px;
    coll   = (m_state == 1) && ((opaque && m_lp != 2'b00) || int'(by) >= 484);

    nstate = m_state;
    if (rst) begin
      nstate  = 0;
      m_score = 0;
      m_flash = 0;
      m_rgb   = 12'h000;
      m_br    = 1'b0;
      m_in    = 1'b0;
      m_lp    = 2'b00;
      m_lr    = '0;
    end else begin
      m_rgb = !m_br ? 12'h000 : (m_flash > 0 ? ~colour : colour);
      case (m_state)
        0: if (st) begin nstate = 1; m_score = 0; end
        1: begin
          if (coll) nstate = 2;
          else if (pp && m_score < 9999) m_score++;
        end
        default: if (st) nstate = 0;
      endcase
`ifdef VGA_COMP_HIT_FLASH_EN
      if (m_state == 1 && nstate == 2) m_flash = 8;
      else if (m_state == 2 && nstate == 0) m_flash = 0;
      else if (h == 10'd0 && v == 10'd0 && m_flash > 0) m_flash--;
`endif
      m_br = br;
      m_in = ins;
      m_lp = lp;
      m_lr = lr;
    end
    m_row   = (int'(v) - int'(by)) & 15;
    m_col   = (int'(h) - 200) & 15;
    m_state = nstate;

    @(posedge clk);
    #1;
    pix.sprite_px = rom[addr[7:4]][addr[3:0]];
    check_eq("rgb", 32'(pix.rgb), 32'(m_rgb));
    check_eq("game_state", 32'(game_state), 32'(m_state));
    check_eq("score", 32'(score), 32'(to_bcd(m_score)));
    check_eq("pipe_run_en", 32'(pipe_run_en), 32'(m_state == 1));
  endtask

  initial begin
    int          off;
    logic [9:0]  rh, rv, rby;
    logic [1:0]  rlp;
    m_state = 0; m_score = 0; m_flash = 0;
    m_br = 0; m_in = 0; m_row = 0; m_col = 0; m_lp = 0; m_lr = 0; m_rgb = 0;
    pix.sprite_px = 12'h000;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        rom[i][j] = ($urandom_range(0, 3) == 0) ? 12'h0FF : 12'($urandom);
      end
    end
    rom[0][0] = 12'hF80;
    rom[0][1] = 12'h0FF;

    // Reset, then start with a plain background pixel
    repeat (3) step(1, 0, 0, 0, 10'd0, 10'd0, 10'd100, 2'b00, 24'h0);
    step(0, 1, 0, 1, 10'd150, 10'd50, 10'd100, 2'b00, 24'h0);
    step(0, 0, 0, 0, 10'd150, 10'd50, 10'd100, 2'b00, 24'h0);
    step(0, 0, 0, 0, 10'd150, 10'd50, 10'd100, 2'b00, 24'h0);
    repeat (11) step(0, 0, 1, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);

    // Transparent sprite over layer 0: layer colour, no death; then opaque hit
    step(0, 0, 0, 1, 10'd201, 10'd100, 10'd100, 2'b01, {12'h123, 12'h0A0});
    step(0, 0, 0, 1, 10'd200, 10'd100, 10'd100, 2'b01, {12'h123, 12'h0A0});
    repeat (3) step(0, 0, 0, 1, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);

    // Score 4, then collision and pass pulse together
    step(0, 1, 0, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);
    step(0, 1, 0, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);
    repeat (4) step(0, 0, 1, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);
    step(0, 0, 0, 1, 10'd200, 10'd100, 10'd100, 2'b10, {12'h321, 12'h0A0});
    step(0, 0, 1, 1, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);
    step(0, 0, 1, 1, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);

    // Reset mid-run
    step(0, 1, 0, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);
    step(0, 1, 0, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);
    repeat (3) step(0, 0, 1, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);
    step(1, 0, 1, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);

    // Count up to saturation
    step(0, 1, 0, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);
    repeat (10005) step(0, 0, 1, 0, 10'd10, 10'd10, 10'd100, 2'b00, 24'h0);

    // Randomised play
    for (int n = 0; n < 5000; n++) begin
      rby = ($urandom_range(0, 49) == 0) ? 10'($urandom) : 10'($urandom_range(90, 130));
      rh  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(195, 220)) : 10'($urandom_range(0, 799));
      off = $urandom_range(0, 24) - 4;
      rv  = 10'(int'(rby) + off);
      if ($urandom_range(0, 15) == 0) begin
        rh = 10'd0;
        rv = 10'd0;
      end
      rlp = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
           rh, rv, rby, rlp, 24'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
